// File: rtl/hv_pkg.sv
// Shared constants and helpers for the PPU raster timing counters.
package hv_pkg;

    localparam int HV_H_LAST_NTSC = 340;
    localparam int HV_V_LAST_NTSC = 261;
    localparam int HV_V_LAST_PAL  = 311;
    localparam int HV_VB_LINE     = 241;

    // Last line of a frame for the default NTSC/PAL geometries.
    function automatic int hv_vlast(input logic mode);
        return mode ? HV_V_LAST_PAL : HV_V_LAST_NTSC;
    endfunction

endpackage

// File: rtl/hv_wrap_counter.sv
// Generic W-bit counter with synchronous clear, synchronous wrap-to-zero
// and an increment enable. Clear beats wrap, wrap beats increment.
module hv_wrap_counter #(
    parameter int W = 9
) (
    input  logic         PCLK,
    input  logic         RES,
    input  logic         clr,
    input  logic         inc,
    input  logic         wrap,
    output logic [W-1:0] q
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear and wrap both return to zero, otherwise step or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared immediately by the asynchronous reset.
    always_ff @(posedge PCLK or posedge RES) begin
        if (RES) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/hv_raster_counter.sv
// Horizontal/vertical raster counter pair for the PPU timing path.
// Adds runtime NTSC/PAL frame length, odd-frame dot skip, a count enable,
// frame parity and a registered vertical-blank flag on top of plain H/V
// counting. H_out/V_out keep the same meaning for downstream decoders.
module hv_raster_counter
    import hv_pkg::*;
#(
    parameter int HW      = 9,
    parameter int VW      = 9,
    parameter int H_LAST  = HV_H_LAST_NTSC,
    parameter int V_LAST0 = HV_V_LAST_NTSC,
    parameter int V_LAST1 = HV_V_LAST_PAL,
    parameter int VB_LINE = HV_VB_LINE,
    parameter int SKIP_EN = 1
) (
    input  logic          PCLK,
    input  logic          RES,
    input  logic          EN,
    input  logic          HC,
    input  logic          VC,
    input  logic          MODE,
    input  logic          SKIP_REQ,
    output logic [HW-1:0] H_out,
    output logic [VW-1:0] V_out,
    output logic          FRAME_ODD,
    output logic          VBLANK,
    output logic          LINE_END,
    output logic          FRAME_END
);

    localparam logic [HW-1:0] HLastW  = HW'(H_LAST);
    localparam logic [HW-1:0] HSkipW  = HW'(H_LAST - 1);
    localparam logic [HW-1:0] HOneW   = HW'(1);
    localparam logic [VW-1:0] VLast0W = VW'(V_LAST0);
    localparam logic [VW-1:0] VLast1W = VW'(V_LAST1);
    localparam logic [VW-1:0] VbLineW = VW'(VB_LINE);

    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;
    logic [HW-1:0] hNext;
    logic [VW-1:0] vNext;
    logic [VW-1:0] vLast;
    logic          skip;
    logic          hWrap;
    logic          vWrap;

    logic          mode_q;
    logic          mode_d;
    logic          frameOdd_q;
    logic          frameOdd_d;
    logic          vblank_q;
    logic          vblank_d;

    // Frame length follows the mode latched at the last frame wrap, and the
    // odd-frame skip shortens the final line by jumping from H_LAST-1 to 0.
    always_comb begin
        vLast = mode_q ? VLast1W : VLast0W;
        skip  = (SKIP_EN != 0) && SKIP_REQ && frameOdd_q
                && (vCount == vLast) && (hCount == HSkipW);
        hWrap = EN && !HC && ((hCount == HLastW) || skip);
        vWrap = hWrap && !VC && (vCount == vLast);
    end

    // Dot counter: clear, wrap at end of line, otherwise advance when enabled.
    hv_wrap_counter #(
        .W (HW)
    ) u_hCounter (
        .PCLK (PCLK),
        .RES  (RES),
        .clr  (HC),
        .inc  (EN),
        .wrap (hWrap),
        .q    (hCount)
    );

    // Line counter advances once per H wrap; HC already blocks hWrap.
    hv_wrap_counter #(
        .W (VW)
    ) u_vCounter (
        .PCLK (PCLK),
        .RES  (RES),
        .clr  (VC),
        .inc  (hWrap),
        .wrap (vWrap),
        .q    (vCount)
    );

    // Look-ahead of the counter state so VBLANK can change on the same edge
    // that produces its trigger position, instead of one dot later.
    always_comb begin
        hNext = hCount;
        if (HC || hWrap) begin
            hNext = '0;
        end else if (EN) begin
            hNext = hCount + HW'(1);
        end

        vNext = vCount;
        if (VC || vWrap) begin
            vNext = '0;
        end else if (hWrap) begin
            vNext = vCount + VW'(1);
        end
    end

    // Frame-level flags: parity and mode move only on a real frame wrap,
    // VBLANK sets entering dot 1 of the blank line and clears at dot 1 of
    // the last line.
    always_comb begin
        mode_d     = mode_q;
        frameOdd_d = frameOdd_q;
        vblank_d   = vblank_q;
        if (vWrap) begin
            mode_d     = MODE;
            frameOdd_d = !frameOdd_q;
        end
        if ((hNext == HOneW) && (vNext == VbLineW)) begin
            vblank_d = 1'b1;
        end else if ((hNext == HOneW) && (vNext == vLast)) begin
            vblank_d = 1'b0;
        end
    end

    // Frame-level flag registers with asynchronous reset.
    always_ff @(posedge PCLK or posedge RES) begin
        if (RES) begin
            mode_q     <= 1'b0;
            frameOdd_q <= 1'b0;
            vblank_q   <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            frameOdd_q <= frameOdd_d;
            vblank_q   <= vblank_d;
        end
    end

    assign H_out     = hCount;
    assign V_out     = vCount;
    assign FRAME_ODD = frameOdd_q;
    assign VBLANK    = vblank_q;
    assign LINE_END  = hWrap;
    assign FRAME_END = vWrap;

endmodule

// File: tb/tb_hv_raster_counter.sv
// Directed testbench for hv_raster_counter using a reduced raster geometry
// so that whole frames run in a few hundred cycles. Every driven edge pushes
// the expected post-edge state into a scoreboard that is popped after the edge.
module tb_hv_raster_counter;

    localparam int TH_LAST = 20;
    localparam int TV0     = 11;
    localparam int TV1     = 15;
    localparam int TVB     = 7;
    localparam int NTSC_LEN = (TV0 + 1) * (TH_LAST + 1);
    localparam int PAL_LEN  = (TV1 + 1) * (TH_LAST + 1);

    typedef struct {
        int h;
        int v;
        bit odd;
        bit vb;
        bit mode;
    } expect_t;

    logic       PCLK;
    logic       RES;
    logic       EN;
    logic       HC;
    logic       VC;
    logic       MODE;
    logic       SKIP_REQ;
    logic [8:0] H_out;
    logic [8:0] V_out;
    logic       FRAME_ODD;
    logic       VBLANK;
    logic       LINE_END;
    logic       FRAME_END;

    int checks = 0;
    int errors = 0;

    expect_t sbq[$];

    int mH;
    int mV;
    bit mOdd;
    bit mVb;
    bit mMode;

    logic modeIn;
    logic skipIn;
    int   preH;
    int   preV;
    logic preLE;
    logic preFE;

    hv_raster_counter #(
        .HW      (9),
        .VW      (9),
        .H_LAST  (TH_LAST),
        .V_LAST0 (TV0),
        .V_LAST1 (TV1),
        .VB_LINE (TVB),
        .SKIP_EN (1)
    ) dut (
        .PCLK      (PCLK),
        .RES       (RES),
        .EN        (EN),
        .HC        (HC),
        .VC        (VC),
        .MODE      (MODE),
        .SKIP_REQ  (SKIP_REQ),
        .H_out     (H_out),
        .V_out     (V_out),
        .FRAME_ODD (FRAME_ODD),
        .VBLANK    (VBLANK),
        .LINE_END  (LINE_END),
        .FRAME_END (FRAME_END)
    );

    // Free-running pixel clock, rising edges at 5, 15, 25, ...
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mH    = 0;
        mV    = 0;
        mOdd  = 1'b0;
        mVb   = 1'b0;
        mMode = 1'b0;
    endtask

    // One pixel-clock edge: drive inputs, check the combinational decodes,
    // push the expected next state, then compare it after the edge.
    task automatic applyStimulus(input logic en, input logic hc, input logic vc);
        expect_t e;
        int      vl;
        bit      sk;
        bit      hw;
        bit      vw;
        EN       = en;
        HC       = hc;
        VC       = vc;
        MODE     = modeIn;
        SKIP_REQ = skipIn;
        #1;
        preH  = int'(H_out);
        preV  = int'(V_out);
        preLE = LINE_END;
        preFE = FRAME_END;

        vl = mMode ? TV1 : TV0;
        sk = skipIn && mOdd && (mV == vl) && (mH == TH_LAST - 1);
        hw = en && !hc && ((mH == TH_LAST) || sk);
        vw = hw && !vc && (mV == vl);
        checkOutput("LINE_END", LINE_END, hw);
        checkOutput("FRAME_END", FRAME_END, vw);

        e.h    = hc ? 0 : (hw ? 0 : (en ? (mH + 1) % 512 : mH));
        e.v    = vc ? 0 : (vw ? 0 : (hw ? (mV + 1) % 512 : mV));
        e.odd  = vw ? !mOdd : mOdd;
        e.mode = vw ? modeIn : mMode;
        if (e.h == 1 && e.v == TVB)     e.vb = 1'b1;
        else if (e.h == 1 && e.v == vl) e.vb = 1'b0;
        else                            e.vb = mVb;
        sbq.push_back(e);

        @(posedge PCLK);
        #1;
        e = sbq.pop_front();
        checkOutput("H_out", H_out, e.h);
        checkOutput("V_out", V_out, e.v);
        checkOutput("FRAME_ODD", FRAME_ODD, e.odd);
        checkOutput("VBLANK", VBLANK, e.vb);
        mH    = e.h;
        mV    = e.v;
        mOdd  = e.odd;
        mVb   = e.vb;
        mMode = e.mode;
    endtask

    // Count edges up to and including the next frame wrap.
    task automatic runFrame(output int len);
        len = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            len++;
        end while (!preFE && len < 1000);
    endtask

    // Advance with EN=1 until the expected position is reached.
    task automatic runTo(input int tv, input int th);
        for (int n = 0; n < 2000; n++) begin
            if (mV == tv && mH == th) break;
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("runTo_V", V_out, tv);
        checkOutput("runTo_H", H_out, th);
    endtask

    // Directed sequence covering reset, free run, skip, VBLANK, PAL, controls.
    initial begin
        int len;
        bit oddSaved;

        RES      = 1'b1;
        EN       = 1'b0;
        HC       = 1'b0;
        VC       = 1'b0;
        MODE     = 1'b0;
        SKIP_REQ = 1'b0;
        modeIn   = 1'b0;
        skipIn   = 1'b0;
        modelReset();

        #3;
        checkOutput("reset_H", H_out, 0);
        checkOutput("reset_V", V_out, 0);
        checkOutput("reset_ODD", FRAME_ODD, 0);
        checkOutput("reset_VBLANK", VBLANK, 0);
        checkOutput("reset_LINE_END", LINE_END, 0);
        checkOutput("reset_FRAME_END", FRAME_END, 0);
        #4;
        RES = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("first_H", H_out, 1);

        $display("[TB] free run, NTSC, no skip");
        runFrame(len);
        checkOutput("frame0_len", len, NTSC_LEN - 1);
        checkOutput("frame0_lastV", preV, TV0);
        checkOutput("frame0_lastH", preH, TH_LAST);
        checkOutput("frame0_odd", FRAME_ODD, 1);
        runFrame(len);
        checkOutput("frame1_len", len, NTSC_LEN);
        checkOutput("frame1_odd", FRAME_ODD, 0);

        $display("[TB] odd-frame dot skip");
        skipIn = 1'b1;
        runFrame(len);
        checkOutput("skip_even_len", len, NTSC_LEN);
        checkOutput("skip_even_odd", FRAME_ODD, 1);
        runFrame(len);
        checkOutput("skip_odd_len", len, NTSC_LEN - 1);
        checkOutput("skip_odd_lastH", preH, TH_LAST - 1);
        checkOutput("skip_odd_lastV", preV, TV0);
        checkOutput("skip_odd_LINE_END", preLE, 1);
        checkOutput("skip_after_H", H_out, 0);
        checkOutput("skip_after_V", V_out, 0);
        skipIn = 1'b0;

        $display("[TB] vertical blank window");
        runTo(TVB, 0);
        checkOutput("vb_before", VBLANK, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("vb_set", VBLANK, 1);
        runTo(TV0, 0);
        checkOutput("vb_hold", VBLANK, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("vb_clear", VBLANK, 0);
        runFrame(len);
        checkOutput("vb_frame_tail", len, TH_LAST);

        $display("[TB] PAL selected mid-frame");
        runTo(5, 0);
        modeIn = 1'b1;
        runFrame(len);
        checkOutput("pal_cur_len", len, NTSC_LEN - 5 * (TH_LAST + 1));
        checkOutput("pal_cur_lastV", preV, TV0);
        runFrame(len);
        checkOutput("pal_next_len", len, PAL_LEN);
        checkOutput("pal_next_lastV", preV, TV1);

        $display("[TB] EN, HC and VC controls");
        runTo(3, TH_LAST);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("en_hold_H", H_out, TH_LAST);
        checkOutput("en_hold_V", V_out, 3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("hc_LINE_END", preLE, 0);
        checkOutput("hc_H", H_out, 0);
        checkOutput("hc_V", V_out, 3);
        runTo(TV1, 5);
        oddSaved = mOdd;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("vc_V", V_out, 0);
        checkOutput("vc_H", H_out, 6);
        checkOutput("vc_odd", FRAME_ODD, oddSaved);

        $display("[TB] asynchronous reset mid-line");
        runTo(9, 13);
        #2;
        RES = 1'b1;
        #1;
        checkOutput("areset_H", H_out, 0);
        checkOutput("areset_V", V_out, 0);
        checkOutput("areset_ODD", FRAME_ODD, 0);
        checkOutput("areset_VBLANK", VBLANK, 0);
        checkOutput("areset_LINE_END", LINE_END, 0);
        checkOutput("areset_FRAME_END", FRAME_END, 0);
        #1;
        RES = 1'b0;
        modelReset();
        sbq.delete();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("areset_resume_H", H_out, 1);
        checkOutput("areset_resume_V", V_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hv_raster_counter.md
# hv_raster_counter

Parametrised horizontal/vertical raster counter pair for the PPU timing path. It is the next generation of the 9-bit H/V counters. Widths and terminal counts are parameters. It adds runtime NTSC/PAL frame-length selection, odd-frame dot skipping, a count enable, a frame-parity flag and a registered vertical-blank flag. Downstream decoders (blanking, sync, fetch sequencing) consume `H_out`/`V_out` exactly as before.

## Interface
- `HW`, 9, H counter width
- `VW`, 9, V counter width
- `H_LAST`, 340, last dot of a line; H wraps to 0 after it
- `V_LAST0`, 261, last line of a frame when `mode_q`=0 (NTSC)
- `V_LAST1`, 311, last line of a frame when `mode_q`=1 (PAL)
- `VB_LINE`, 241, first vertical-blank line
- `SKIP_EN`, 1, enables odd-frame dot skip (0 = never skip)

- `PCLK`  in  1  pixel clock; all state changes on its rising edge
- `RES`  in  1  asynchronous, active-high reset
- `EN`  in  1  count enable; 0 holds H/V (HC/VC still act)
- `HC`  in  1  synchronous H clear
- `VC`  in  1  synchronous V clear
- `MODE`  in  1  frame-length select, sampled only at frame wrap
- `SKIP_REQ`  in  1  rendering active; qualifies the dot skip
- `H_out`  out  HW  current dot
- `V_out`  out  VW  current line
- `FRAME_ODD`  out  1  frame parity, toggles at each frame wrap
- `VBLANK`  out  1  registered vertical-blank flag
- `LINE_END`  out  1  combinational: this edge wraps H (EN=1, HC=0)
- `FRAME_END`  out  1  combinational: this edge wraps V

## Operation
- `v_last` = `mode_q` ? `V_LAST1` : `V_LAST0`. `mode_q` is internal, reset 0, and loads `MODE` on every V wrap.
- `skip` = `SKIP_EN` & `SKIP_REQ` & `FRAME_ODD` & (V==`v_last`) & (H==`H_LAST`-1).
- `hwrap` = `EN` & ~`HC` & (H==`H_LAST` | `skip`).
- `vwrap` = `hwrap` & ~`VC` & (V==`v_last`).
- Priority per edge is `RES` > `HC`/`VC` > `EN` counting.
- H on an edge:
  - `HC`=1: H←0.
  - else if `hwrap`: H←0.
  - else if `EN`: H←H+1.
  - else: hold.
- V on an edge:
  - `VC`=1: V←0.
  - else if `vwrap`: V←0.
  - else if `hwrap`: V←V+1.
  - else: hold.
  - `HC` suppresses the V advance on that edge.
- `FRAME_ODD` toggles on `vwrap` only. `VC` does not toggle it.
- `VBLANK`:
  - Set on the edge whose next state is (V=`VB_LINE`, H=1).
  - Cleared on the edge whose next state is (V=`v_last`, H=1).
  - Otherwise holds.
  - Set and clear are mutually exclusive, given `VB_LINE` ≠ `v_last`.
- Arithmetic is unsigned and modulo 2^HW / 2^VW. If H or V exceeds its terminal (possible only through a width/parameter mismatch), it counts on to wrap at 2^W. This is not an error.
- `LINE_END` = `hwrap`; `FRAME_END` = `vwrap`. Both are pure decodes of current state and inputs, valid in the cycle before the wrapping edge.

## Timing
- Reset (async, while `RES`=1): `H_out`=0, `V_out`=0, `FRAME_ODD`=0, `VBLANK`=0, `mode_q`=0. `LINE_END` and `FRAME_END` therefore read 0.
- First edge after `RES` falls with `EN`=1 gives H=1.
- Latency: every output except `LINE_END`/`FRAME_END` is a flop output and changes one `PCLK` edge after its cause.
- Line length is `H_LAST`+1 dots, or `H_LAST` dots on a skipped line.
- Frame length is (`v_last`+1)·(`H_LAST`+1) dots, minus 1 on a skip.
- A `MODE` change mid-frame has no effect until the next V wrap.
- `RES` asserted mid-line clears all state immediately, with no edge needed.

## Structure
- Package `hv_pkg` holds:
  - default constants `HV_H_LAST_NTSC`=340, `HV_V_LAST_NTSC`=261, `HV_V_LAST_PAL`=311, `HV_VB_LINE`=241;
  - function `hv_vlast(mode)`.
- One sub-module `hv_wrap_counter`, parametrised on width. Ports: `PCLK`, `RES`, `clr`, `inc`, `wrap`, `q`. It is instantiated once for H and once for V.
- Skip/parity/`VBLANK`/`mode_q` logic lives in the top.

## Test plan
- Free run: `MODE`=0, `SKIP_REQ`=0, `EN`=1 for 2 frames → H sequence …339,340,0. V goes 261→0 at H 340→0. Each frame is 89342 cycles. `FRAME_ODD` goes 0→1→0.
- Odd skip: `SKIP_REQ`=1 → even frame 89342 cycles, odd frame 89341. On the odd frame (V=261, H=339) is followed by (0,0), with `LINE_END`=`FRAME_END`=1 in that cycle.
- PAL: `MODE`=1 set at V=100 → current frame still wraps at V=261. The next frame wraps at V=311, i.e. 106392 cycles.
- VBLANK: `VBLANK` rises on the edge giving (241,1) and falls on the edge giving (261,1). It is 0 at (241,0).
- Controls: `EN`=0 for 5 cycles at (10,340) → state holds. `HC`=1 at (10,340) → (10,0): V does not advance and `LINE_END`=0. `VC`=1 at V=261 → V=0 and `FRAME_ODD` is unchanged.
- Async reset: pulse `RES` between edges at (150,200) → all outputs are 0 before the next edge. Counting resumes at H=1.
